// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter sharing one ALU, one-entry registered response
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [DATA_WIDTH-1:0]    req0_srca,
  input  logic [DATA_WIDTH-1:0]    req0_srcb,
  input  logic [OPCODE_LENGTH-1:0] req0_op,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [DATA_WIDTH-1:0]    req1_srca,
  input  logic [DATA_WIDTH-1:0]    req1_srcb,
  input  logic [OPCODE_LENGTH-1:0] req1_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_result,
  output logic                     rsp_id,
  output logic                     rsp_illegal
);
  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                   r_state, w_next;
  logic                     r_last;
  logic [DATA_WIDTH-1:0]    r_result;
  logic                     r_id, r_illegal;
  logic                     w_can, w_gnt0, w_gnt1, w_acc, w_ill;
  logic [DATA_WIDTH-1:0]    w_a, w_b, w_res;
  logic [OPCODE_LENGTH-1:0] w_op;

  // Output-register occupancy: fill on accept, empty on a drain with no refill
  always_ff @(posedge clk)
    r_state <= reset ? EMPTY : w_next;

  // Grant, next occupancy and the ALU on the granted requester's operands
  always_comb begin
    w_can  = !reset && (r_state == EMPTY || rsp_ready);
    w_gnt0 = w_can && req0_valid && (!req1_valid || r_last);
    w_gnt1 = w_can && req1_valid && (!req0_valid || !r_last);
    w_acc  = w_gnt0 || w_gnt1;
    w_next = w_acc ? FULL : (r_state == FULL && rsp_ready) ? EMPTY : r_state;
    w_a    = w_gnt1 ? req1_srca : req0_srca;
    w_b    = w_gnt1 ? req1_srcb : req0_srcb;
    w_op   = w_gnt1 ? req1_op : req0_op;
    w_res  = w_op == OP_AND ? w_a & w_b :
             w_op == OP_OR  ? w_a | w_b :
             w_op == OP_ADD ? w_a + w_b :
             w_op == OP_EQ  ? {{(DATA_WIDTH-1){1'b0}}, w_a == w_b} : '0;
    w_ill  = !(w_op == OP_AND || w_op == OP_OR || w_op == OP_ADD || w_op == OP_EQ);
  end

  // Response payload and round-robin pointer update only on accept; pointer resets to 1 so req0 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result  <= '0;
      r_id      <= 1'b0;
      r_illegal <= 1'b0;
      r_last    <= 1'b1;
    end else if (w_acc) begin
      r_result  <= w_res;
      r_id      <= w_gnt1;
      r_illegal <= w_ill;
      r_last    <= w_gnt1;
    end
  end

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign rsp_valid   = r_state == FULL;
  assign rsp_result  = r_result;
  assign rsp_id      = r_id;
  assign rsp_illegal = r_illegal;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scoreboard bench for alu_arbiter
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_srca, req0_srcb, req1_srca, req1_srcb;
  logic [3:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_illegal;
  logic [31:0] rsp_result;
  int          checks = 0;
  int          errors = 0;
  logic [33:0] q[$];

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic r0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req0_valid = v; req0_srca = a; req0_srcb = b; req0_op = op;
  endtask

  task automatic r1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    req1_valid = v; req1_srca = a; req1_srcb = b; req1_op = op;
  endtask

  task automatic rdy(input string name, input logic e0, input logic e1);
    #1;
    chk(name, {32'd0, req0_ready, req1_ready}, {32'd0, e0, e1});
  endtask

  task automatic rsp(input string name, input logic v, input logic id, input logic ill, input logic [31:0] res);
    chk(name, {rsp_valid, rsp_id, rsp_illegal, rsp_result[30:0]}, {v, id, ill, res[30:0]});
    chk({name, "_msb"}, {33'd0, rsp_result[31]}, {33'd0, res[31]});
  endtask

  // Scoreboard monitor: every drained response must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got id=%0d res=%h expected none", rsp_id, rsp_result);
      end else begin
        chk("rsp_pop", {rsp_id, rsp_illegal, rsp_result}, q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; rsp_ready = 1'b0;
    r0(1'b1, 32'd1, 32'd1, 4'b0010);
    r1(1'b0, 32'd0, 32'd0, 4'b0000);
    tick(); tick();
    rdy("rdy_in_reset", 1'b0, 1'b0);
    rsp("reset_state", 1'b0, 1'b0, 1'b0, 32'd0);
    r0(1'b0, 32'd0, 32'd0, 4'b0000);
    reset = 1'b0;
    tick();
    rsp("no_accept_from_reset", 1'b0, 1'b0, 1'b0, 32'd0);

    rsp_ready = 1'b1;
    r0(1'b1, 32'h5, 32'h3, 4'b0010); q.push_back({1'b0, 1'b0, 32'h8});
    rdy("rdy_single0", 1'b1, 1'b0);
    tick();
    rsp("add_result", 1'b1, 1'b0, 1'b0, 32'h8);
    r0(1'b0, 32'd0, 32'd0, 4'b0000);
    r1(1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1000); q.push_back({1'b1, 1'b0, 32'h1});
    rdy("rdy_single1", 1'b0, 1'b1);
    tick();
    rsp("eq_result", 1'b1, 1'b1, 1'b0, 32'h1);
    r1(1'b0, 32'd0, 32'd0, 4'b0000);
    r0(1'b1, 32'hFFFFFFFF, 32'h1, 4'b0010); q.push_back({1'b0, 1'b0, 32'h0});
    tick();
    r0(1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000); q.push_back({1'b0, 1'b0, 32'hF000F000});
    tick();
    r0(1'b0, 32'd0, 32'd0, 4'b0000);
    r1(1'b1, 32'h0F0F0000, 32'h0000F0F0, 4'b0001); q.push_back({1'b1, 1'b0, 32'h0F0FF0F0});
    tick();
    r1(1'b1, 32'h12345678, 32'h1, 4'b0101); q.push_back({1'b1, 1'b1, 32'h0});
    tick();
    rsp("illegal_result", 1'b1, 1'b1, 1'b1, 32'h0);
    r1(1'b0, 32'd0, 32'd0, 4'b0000);
    tick();
    rsp("drained_empty", 1'b0, 1'b1, 1'b1, 32'h0);

    reset = 1'b1; tick(); reset = 1'b0;
    r0(1'b1, 32'h1, 32'h1, 4'b0010);
    r1(1'b1, 32'hA, 32'hA, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      q.push_back(i % 2 == 0 ? {1'b0, 1'b0, 32'h2} : {1'b1, 1'b0, 32'h14});
      rdy($sformatf("rr_grant%0d", i), i % 2 == 0, i % 2 == 1);
      tick();
      chk($sformatf("rr_nobubble%0d", i), {33'd0, rsp_valid}, 34'd1);
    end
    r0(1'b0, 32'd0, 32'd0, 4'b0000);
    r1(1'b0, 32'd0, 32'd0, 4'b0000);
    tick();

    r0(1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 4'b0000); q.push_back({1'b0, 1'b0, 32'hF000F000});
    tick();
    rsp_ready = 1'b0;
    r0(1'b1, 32'h1, 32'h2, 4'b0001);
    r1(1'b1, 32'h7, 32'h8, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      rdy($sformatf("bp_rdy%0d", i), 1'b0, 1'b0);
      rsp($sformatf("bp_stable%0d", i), 1'b1, 1'b0, 1'b0, 32'hF000F000);
      tick();
    end
    rsp_ready = 1'b1;
    q.push_back({1'b1, 1'b0, 32'hF});
    rdy("bp_release", 1'b0, 1'b1);
    tick();
    rsp("bp_refill", 1'b1, 1'b1, 1'b0, 32'hF);
    r0(1'b0, 32'd0, 32'd0, 4'b0000);
    r1(1'b0, 32'd0, 32'd0, 4'b0000);
    tick();

    r0(1'b1, 32'h1, 32'h2, 4'b0001); q.push_back({1'b0, 1'b0, 32'h3});
    tick();
    r0(1'b0, 32'd0, 32'd0, 4'b0000);
    rsp_ready = 1'b0;
    r1(1'b1, 32'h1, 32'h2, 4'b0010);
    rdy("withdraw_blocked", 1'b0, 1'b0);
    tick();
    r1(1'b0, 32'd0, 32'd0, 4'b0000);
    tick();
    rsp_ready = 1'b1;
    tick(); tick();
    rsp("withdraw_none", 1'b0, 1'b0, 1'b0, 32'h3);

    rsp_ready = 1'b0;
    r0(1'b1, 32'h9, 32'h9, 4'b0010);
    tick();
    rsp("full_before_reset", 1'b1, 1'b0, 1'b0, 32'h12);
    reset = 1'b1;
    r1(1'b1, 32'h1, 32'h1, 4'b0010);
    rdy("rdy_mid_reset", 1'b0, 1'b0);
    tick();
    rsp("mid_reset_state", 1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0; rsp_ready = 1'b1;
    r0(1'b1, 32'hFFFFFFFF, 32'h12345678, 4'b0000); q.push_back({1'b0, 1'b0, 32'h12345678});
    rdy("post_reset_conflict", 1'b1, 1'b0);
    tick();
    r0(1'b0, 32'd0, 32'd0, 4'b0000);
    r1(1'b0, 32'd0, 32'd0, 4'b0000);
    tick(); tick();

    chk("queue_empty", 34'(q.size()), 34'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter that shares one integer ALU (AND/OR/ADD/equal-compare, 4-bit operation code) between two independent sources, e.g. the EX stage and a branch/auxiliary unit. It accepts operand/opcode requests over valid/ready handshakes and computes the result in the internal ALU on the accept cycle. The result and the requester ID are held in a one-entry output register that drains over a valid/ready response port with backpressure.

## Interface
- DATA_WIDTH, 32, operand and result width
- OPCODE_LENGTH, 4, ALU operation code width
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 presents a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_srca, req0_srcb  in  DATA_WIDTH each  requester 0 operands
- req0_op  in  OPCODE_LENGTH  requester 0 operation
- req1_valid, req1_ready, req1_srca, req1_srcb, req1_op  same as requester 0, for requester 1
- rsp_valid  out  1  output register holds a result
- rsp_ready  in  1  consumer takes result this cycle
- rsp_result  out  DATA_WIDTH  ALU result
- rsp_id  out  1  requester that issued the result (0/1)
- rsp_illegal  out  1  issued opcode was not a supported encoding

## Operation
- Supported operations: 0000 AND, 0001 OR, 0010 ADD (modulo 2^DATA_WIDTH, carry dropped), 1000 equal (result 1 if srca==srcb, else 0, zero-extended). All other codes: result 0, rsp_illegal=1.
- Output-register state: EMPTY (rsp_valid=0) or FULL (rsp_valid=1).
- can_accept = EMPTY, or FULL with rsp_ready=1 (drain and refill in the same cycle).
- Grant, combinational: if can_accept and exactly one reqN_valid, grant N. If both are valid, grant the requester not granted last (last_grant pointer). If can_accept=0, no grant.
- reqN_ready = grant to N. At most one ready is high per cycle. ready never depends on the other requester's ready.
- Accept edge (reqN_valid && reqN_ready):
  - register ALU(reqN_srca, reqN_srcb, reqN_op) into rsp_result
  - rsp_id=N, rsp_illegal per opcode, rsp_valid=1, last_grant=N
- Drain edge without accept (rsp_valid && rsp_ready, no grant): rsp_valid=0. rsp_result/rsp_id/rsp_illegal hold their last values.
- Backpressure: while rsp_valid && !rsp_ready, all response outputs are stable and both readies are 0.
- Requesters may drop valid without being accepted. The arbiter keeps no request state beyond last_grant.

## Timing
- Reset (sampled high at an edge): rsp_valid=0, rsp_result=0, rsp_id=0, rsp_illegal=0, last_grant=1, so requester 0 wins the first conflict. While reset is high, req0_ready=req1_ready=0.
- Reset during FULL: the pending result is discarded with no response. A request presented during reset is not accepted.
- Latency: request accepted at edge k gives rsp_valid=1 from edge k until the cycle after its drain edge.
- Throughput: 1 result/cycle when rsp_ready is held high. Both requesters continuously valid: grants alternate 0,1,0,1…
- Simultaneous drain and accept: the new result replaces the old at the same edge. rsp_valid stays 1 with no bubble.
- Starvation bound: a continuously valid requester is accepted within 2 accept opportunities.

## Test plan
- Reset then single requests: req0 ADD 0x0000_0005 + 0x0000_0003 → next cycle rsp_valid=1, rsp_result=0x8, rsp_id=0. Then req1 op 1000 with 0xDEAD_BEEF,0xDEAD_BEEF → rsp_result=1, rsp_id=1.
- Arithmetic/ops: ADD 0xFFFF_FFFF + 0x1 → 0x0. AND 0xF0F0_F0F0 & 0xFF00_FF00 → 0xF000_F000. OR 0x0F0F_0000 | 0x0000_F0F0 → 0x0F0F_F0F0. Op 0101 → result 0, rsp_illegal=1.
- Conflict/round-robin: both valid for 4 cycles with rsp_ready=1 → first grant req0 after reset, grants alternate 0,1,0,1, back-to-back rsp_valid with no bubble.
- Backpressure: fill with req0 AND, hold rsp_ready=0 for 3 cycles while both requesters are valid → both readies 0, rsp_* stable. Raise rsp_ready → drain and accept the next request (req1) on the same edge.
- Reset mid-operation: FULL with rsp_ready=0, assert reset 1 cycle → rsp_valid=0, rsp_result=0, readies 0 during reset. The next conflict is granted to req0.
- Withdrawal: req1 valid for one cycle while FULL/blocked, then dropped → no response with rsp_id=1 is ever produced.
